regfile_8x32: RTL and testbench



---
 rtl/regfile_8x32.sv | 62 ++++++
 tb/tb_regfile_8x32.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_8x32.sv
`default_nettype none
// ============================================================================
// Module   : regfile_8x32
// Purpose  : 8 x 32-bit register file, one synchronous write port and two
//            combinational read ports. Define REGFILE_BYPASS_EN for
//            write-through forwarding onto the read ports.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_8x32 #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 3,
    parameter int NUM_REGS = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in,
    input  logic [ADDR_W-1:0] w,
    input  logic              we,
    input  logic [ADDR_W-1:0] r1,
    input  logic [ADDR_W-1:0] r2,
    output logic [DATA_W-1:0] out1,
    output logic [DATA_W-1:0] out2
);

    logic [DATA_W-1:0] w_entry [NUM_REGS];

    // Per-entry decode: an unknown write address never matches, so the write is dropped.
    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_regs
            logic [DATA_W-1:0] r_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_q <= '0;
                end else if (we && (w == ADDR_W'(gi))) begin
                    r_q <= in;
                end
            end

            assign w_entry[gi] = r_q;
        end
    endgenerate

`ifdef REGFILE_BYPASS_EN
    logic w_fwd1;
    logic w_fwd2;

    always_comb begin
        w_fwd1 = rst_n && we && (w == r1);
        w_fwd2 = rst_n && we && (w == r2);
        out1   = w_fwd1 ? in : w_entry[r1];
        out2   = w_fwd2 ? in : w_entry[r2];
    end
`else
    always_comb begin
        out1 = w_entry[r1];
        out2 = w_entry[r2];
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_regfile_8x32.sv
`default_nettype none
// Self-checking bench for regfile_8x32: expected read data is queued as reads
// are issued and popped when the combinational outputs are sampled.
module tb_regfile_8x32;

    logic        clk;
    logic        rst_n;
    logic [31:0] in;
    logic [2:0]  w;
    logic        we;
    logic [2:0]  r1;
    logic [2:0]  r2;
    logic [31:0] out1;
    logic [31:0] out2;

    int          checks;
    int          errors;
    logic [31:0] exp_q [$];
    logic [31:0] e1;
    logic [31:0] e2;

    regfile_8x32 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .in    (in),
        .w     (w),
        .we    (we),
        .r1    (r1),
        .r2    (r2),
        .out1  (out1),
        .out2  (out2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst_n = 1'b0;
        we    = 1'b1;
        w     = 3'd2;
        in    = 32'hFFFF_FFFF;
        r1    = 3'd0;
        r2    = 3'd0;
        repeat (2) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            r1 = 3'(i);
            r2 = 3'(7 - i);
            exp_q.push_back(32'h0);
            exp_q.push_back(32'h0);
            #1;
            e1 = exp_q.pop_front();
            e2 = exp_q.pop_front();
            checks++;
            if (out1 !== e1 || out2 !== e2) begin
                errors++;
                $display("FAIL reset_init addr=%0d out1=%h out2=%h required %h/%h", i, out1, out2, e1, e2);
            end
        end
        @(negedge clk);
        we    = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        @(negedge clk);
        we = 1'b1; w = 3'd0; in = 32'hABCDABCD;
        @(negedge clk);
        w = 3'd1; in = 32'hDEADBEEF;
        @(negedge clk);
        we = 1'b0; in = 32'h0; r1 = 3'd0; r2 = 3'd1;
        for (int c = 0; c < 3; c++) begin
            exp_q.push_back(32'hABCDABCD);
            exp_q.push_back(32'hDEADBEEF);
            #1;
            e1 = exp_q.pop_front();
            e2 = exp_q.pop_front();
            checks++;
            if (out1 !== e1 || out2 !== e2) begin
                errors++;
                $display("FAIL basic cycle=%0d out1=%h out2=%h required %h/%h", c, out1, out2, e1, e2);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_write_disable();
        @(negedge clk);
        we = 1'b0; w = 3'd0; in = 32'h12345678; r1 = 3'd0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            exp_q.push_back(32'hABCDABCD);
            #1;
            e1 = exp_q.pop_front();
            checks++;
            if (out1 !== e1) begin
                errors++;
                $display("FAIL write_disable edge=%0d out1=%h required %h", c, out1, e1);
            end
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            we = 1'b1; w = 3'(i); in = 32'h11111111 * (i + 1);
        end
        @(negedge clk);
        we = 1'b0;
        r1 = 3'd4; r2 = 3'd7;
        exp_q.push_back(32'h55555555);
        exp_q.push_back(32'h88888888);
        #1;
        e1 = exp_q.pop_front();
        e2 = exp_q.pop_front();
        checks++;
        if (out1 !== e1 || out2 !== e2) begin
            errors++;
            $display("FAIL fill out1=%h out2=%h required %h/%h", out1, out2, e1, e2);
        end
        // Assert reset between edges and check that it takes effect with no clock.
        #1 rst_n = 1'b0;
        for (int i = 0; i < 8; i++) begin
            r1 = 3'(i);
            r2 = 3'(7 - i);
            exp_q.push_back(32'h0);
            exp_q.push_back(32'h0);
            #0.5;
            e1 = exp_q.pop_front();
            e2 = exp_q.pop_front();
            checks++;
            if (out1 !== e1 || out2 !== e2) begin
                errors++;
                $display("FAIL async_reset addr=%0d out1=%h out2=%h required %h/%h", i, out1, out2, e1, e2);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            #1;
            r1 = 3'(i);
            exp_q.push_back(32'h0);
            #1;
            e1 = exp_q.pop_front();
            checks++;
            if (out1 !== e1) begin
                errors++;
                $display("FAIL post_reset addr=%0d out1=%h required %h", i, out1, e1);
            end
        end
    endtask

    task automatic test_same_addr();
        @(negedge clk);
        we = 1'b1; w = 3'd5; in = 32'hCAFEF00D;
        @(negedge clk);
        we = 1'b0; r1 = 3'd5; r2 = 3'd5;
        exp_q.push_back(32'hCAFEF00D);
        exp_q.push_back(32'hCAFEF00D);
        #1;
        e1 = exp_q.pop_front();
        e2 = exp_q.pop_front();
        checks++;
        if (out1 !== e1 || out2 !== e2) begin
            errors++;
            $display("FAIL same_addr out1=%h out2=%h required %h/%h", out1, out2, e1, e2);
        end
    endtask

    task automatic test_read_during_write();
        @(negedge clk);
        we = 1'b1; w = 3'd3; in = 32'hAAAA5555;
        @(negedge clk);
        we = 1'b1; w = 3'd3; in = 32'h5555AAAA; r1 = 3'd3; r2 = 3'd5;
`ifdef REGFILE_BYPASS_EN
        exp_q.push_back(32'h5555AAAA);
`else
        exp_q.push_back(32'hAAAA5555);
`endif
        exp_q.push_back(32'hCAFEF00D);
        #1;
        e1 = exp_q.pop_front();
        e2 = exp_q.pop_front();
        checks++;
        if (out1 !== e1 || out2 !== e2) begin
            errors++;
            $display("FAIL rdw_before out1=%h out2=%h required %h/%h", out1, out2, e1, e2);
        end
        @(posedge clk);
        exp_q.push_back(32'h5555AAAA);
        #1;
        e1 = exp_q.pop_front();
        checks++;
        if (out1 !== e1) begin
            errors++;
            $display("FAIL rdw_after out1=%h required %h", out1, e1);
        end
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic test_sweep();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            we = 1'b1; w = 3'(i); in = ~(32'(i));
        end
        @(negedge clk);
        we = 1'b0; in = 32'h0;
        for (int i = 0; i < 8; i++) begin
            r1 = 3'(i);
            r2 = 3'(7 - i);
            exp_q.push_back(~(32'(i)));
            exp_q.push_back(~(32'(7 - i)));
            #1;
            e1 = exp_q.pop_front();
            e2 = exp_q.pop_front();
            checks++;
            if (out1 !== e1 || out2 !== e2) begin
                errors++;
                $display("FAIL sweep step=%0d out1=%h out2=%h required %h/%h", i, out1, out2, e1, e2);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_write_disable();
        test_async_reset();
        test_same_addr();
        test_read_during_write();
        test_sweep();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain left=%0d required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
